wb_retire_queue: RTL and testbench

- Dual-issue writeback buffer that drives the write side of the dual-write, quad-read register file.
- Accepts up to two completed results per cycle from the two execution pipes and holds them in an in-order circular queue.
- Drains up to two entries per cycle onto the regfile write ports (we3/wa3/wd3, we3_2/wa3_2/wd3_2).
- Forwards still-pending results to all four regfile read addresses so decode never sees stale data.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/fwd_match.sv | 32 +++
 rtl/wb_retire_queue.sv | 165 ++++++++++++++++
 tb/tb_wb_retire_queue.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback retire queue.
// An entry is one completed result waiting to be written to the regfile.
package wb_pkg;
   localparam int unsigned XLEN   = 32;
   localparam int unsigned AW     = 5;
   localparam int unsigned NUM_RD = 4;

   typedef struct packed {
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
   } entry_t;

   // What the write ports do with the head of the queue this cycle.
   typedef enum logic [1:0] {
      DR_NONE,
      DR_ONE,
      DR_PAIR,
      DR_COLLAPSE
   } drain_e;
endpackage

// File: rtl/fwd_match.sv
// Youngest-first match of one read address against the pending queue entries.
// Misses, and reads of register 0, return hit=0 and data=0.
module fwd_match
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   localparam int unsigned PW = $clog2(DEPTH)
)
(
   input  entry_t [DEPTH-1:0] entries,
   input  logic [DEPTH-1:0]   valid,
   input  logic [PW-1:0]      head,
   input  logic [AW-1:0]      addr,
   output logic               hit,
   output logic [XLEN-1:0]    data
);
   logic [PW-1:0] idx;

   // Walk from oldest to youngest so the last match is the youngest one.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = head;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if ((addr != '0) && valid[idx] && (entries[idx].addr == addr)) begin
            hit  = 1'b1;
            data = entries[idx].data;
         end
      end
   end
endmodule

// File: rtl/wb_retire_queue.sv
// Dual-issue in-order writeback queue feeding the two regfile write ports,
// with forwarding of pending results to the four regfile read addresses.
module wb_retire_queue
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 8
)
(
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid0,
   input  logic [AW-1:0]   in_addr0,
   input  logic [XLEN-1:0] in_data0,
   input  logic            in_valid1,
   input  logic [AW-1:0]   in_addr1,
   input  logic [XLEN-1:0] in_data1,
   output logic            in_ready,
   input  logic            drain_en,
   output logic            we3,
   output logic [AW-1:0]   wa3,
   output logic [XLEN-1:0] wd3,
   output logic            we3_2,
   output logic [AW-1:0]   wa3_2,
   output logic [XLEN-1:0] wd3_2,
   input  logic [AW-1:0]   fwd_addr0,
   input  logic [AW-1:0]   fwd_addr1,
   input  logic [AW-1:0]   fwd_addr2,
   input  logic [AW-1:0]   fwd_addr3,
   output logic            fwd_hit0,
   output logic            fwd_hit1,
   output logic            fwd_hit2,
   output logic            fwd_hit3,
   output logic [XLEN-1:0] fwd_data0,
   output logic [XLEN-1:0] fwd_data1,
   output logic [XLEN-1:0] fwd_data2,
   output logic [XLEN-1:0] fwd_data3,
   output logic            overflow
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   entry_t [DEPTH-1:0] mem;
   logic [PW-1:0]      head;
   logic [PW-1:0]      tail;
   logic [CW-1:0]      count;
   logic [DEPTH-1:0]   valid;
   logic               push0;
   logic               push1;
   logic               reject;
   logic [1:0]         npush;
   logic [1:0]         npop;
   drain_e             drain_mode;
   entry_t             e_head;
   entry_t             e_next;

   assign in_ready = (count <= CW'(DEPTH - 2));
   assign reject   = (in_valid0 | in_valid1) & ~in_ready;
   assign push0    = in_ready & in_valid0 & (in_addr0 != '0);
   assign push1    = in_ready & in_valid1 & (in_addr1 != '0);
   assign npush    = 2'(push0) + 2'(push1);

   // An entry is live when its distance from head is below count.
   always_comb begin
      valid = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         valid[i] = ({1'b0, PW'(i) - head} < count);
      end
   end

   assign e_head = mem[head];
   assign e_next = mem[head + PW'(1)];

   always_comb begin
      drain_mode = DR_NONE;
      if (drain_en && (count >= CW'(2))) begin
         drain_mode = (e_head.addr == e_next.addr) ? DR_COLLAPSE : DR_PAIR;
      end else if (drain_en && (count == CW'(1))) begin
         drain_mode = DR_ONE;
      end
   end

   always_comb begin
      we3   = 1'b0;
      wa3   = '0;
      wd3   = '0;
      we3_2 = 1'b0;
      wa3_2 = '0;
      wd3_2 = '0;
      npop  = 2'd0;
      case (drain_mode)
         DR_ONE: begin
            we3  = 1'b1;
            wa3  = e_head.addr;
            wd3  = e_head.data;
            npop = 2'd1;
         end
         DR_PAIR: begin
            we3   = 1'b1;
            wa3   = e_head.addr;
            wd3   = e_head.data;
            we3_2 = 1'b1;
            wa3_2 = e_next.addr;
            wd3_2 = e_next.data;
            npop  = 2'd2;
         end
         // Same destination twice: only the younger value reaches the regfile.
         DR_COLLAPSE: begin
            we3_2 = 1'b1;
            wa3_2 = e_next.addr;
            wd3_2 = e_next.data;
            npop  = 2'd2;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         head  <= head + PW'(npop);
         tail  <= tail + PW'(npush);
         count <= count + CW'(npush) - CW'(npop);
         if (reject) overflow <= 1'b1;
      end
   end

   // Slot 1 lands right behind slot 0, or at tail when slot 0 was dropped.
   always_ff @(posedge clk) begin
      if (push0) mem[tail] <= {in_addr0, in_data0};
      if (push1) mem[tail + PW'(push0)] <= {in_addr1, in_data1};
   end

   logic [AW-1:0]   rd_addr [NUM_RD];
   logic            rd_hit  [NUM_RD];
   logic [XLEN-1:0] rd_data [NUM_RD];

   assign rd_addr[0] = fwd_addr0;
   assign rd_addr[1] = fwd_addr1;
   assign rd_addr[2] = fwd_addr2;
   assign rd_addr[3] = fwd_addr3;

   for (genvar r = 0; r < NUM_RD; r++) begin : g_fwd
      fwd_match #(.DEPTH(DEPTH)) u_match (
         .entries (mem),
         .valid   (valid),
         .head    (head),
         .addr    (rd_addr[r]),
         .hit     (rd_hit[r]),
         .data    (rd_data[r])
      );
   end

   assign fwd_hit0  = rd_hit[0];
   assign fwd_hit1  = rd_hit[1];
   assign fwd_hit2  = rd_hit[2];
   assign fwd_hit3  = rd_hit[3];
   assign fwd_data0 = rd_data[0];
   assign fwd_data1 = rd_data[1];
   assign fwd_data2 = rd_data[2];
   assign fwd_data3 = rd_data[3];
endmodule

// File: tb/tb_wb_retire_queue.sv
// Bench for wb_retire_queue: directed vector table, then a scoreboard-driven
// fill/overflow sequence, a random run through pointer wrap, and a mid-drain reset.
module tb_wb_retire_queue;
   localparam int unsigned DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid0, in_valid1, drain_en;
   logic [4:0]  in_addr0, in_addr1;
   logic [31:0] in_data0, in_data1;
   logic        in_ready, we3, we3_2, overflow;
   logic [4:0]  wa3, wa3_2;
   logic [31:0] wd3, wd3_2;
   logic [4:0]  fwd_addr0, fwd_addr1, fwd_addr2, fwd_addr3;
   logic        fwd_hit0, fwd_hit1, fwd_hit2, fwd_hit3;
   logic [31:0] fwd_data0, fwd_data1, fwd_data2, fwd_data3;

   wb_retire_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid0(in_valid0), .in_addr0(in_addr0), .in_data0(in_data0),
      .in_valid1(in_valid1), .in_addr1(in_addr1), .in_data1(in_data1),
      .in_ready(in_ready), .drain_en(drain_en),
      .we3(we3), .wa3(wa3), .wd3(wd3),
      .we3_2(we3_2), .wa3_2(wa3_2), .wd3_2(wd3_2),
      .fwd_addr0(fwd_addr0), .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2), .fwd_addr3(fwd_addr3),
      .fwd_hit0(fwd_hit0), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_hit3(fwd_hit3),
      .fwd_data0(fwd_data0), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .fwd_data3(fwd_data3),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } ent_t;

   typedef struct {
      logic v0; logic [4:0] a0; logic [31:0] d0;
      logic v1; logic [4:0] a1; logic [31:0] d1;
      logic dr; logic [4:0] fa;
      logic rdy; logic we; logic [4:0] wa; logic [31:0] wd;
      logic we2; logic [4:0] wa2; logic [31:0] wd2;
      logic hit; logic [31:0] fd;
   } vec_t;

   vec_t        tbl[$];
   ent_t        sb[$];
   logic        ovf_m;
   logic [4:0]  fa [4];
   int unsigned errors = 0;
   int unsigned checks = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic add_row(input int v0, a0, d0, v1, a1, d1, dr, fa_i,
                          input int rdy, we, wa, wd, we2, wa2, wd2, hit, fd);
      vec_t r;
      r.v0 = 1'(v0); r.a0 = 5'(a0); r.d0 = 32'(d0);
      r.v1 = 1'(v1); r.a1 = 5'(a1); r.d1 = 32'(d1);
      r.dr = 1'(dr); r.fa = 5'(fa_i);
      r.rdy = 1'(rdy); r.we = 1'(we); r.wa = 5'(wa); r.wd = 32'(wd);
      r.we2 = 1'(we2); r.wa2 = 5'(wa2); r.wd2 = 32'(wd2);
      r.hit = 1'(hit); r.fd = 32'(fd);
      tbl.push_back(r);
   endtask

   function automatic logic get_hit(input int p);
      case (p)
         0: return fwd_hit0;
         1: return fwd_hit1;
         2: return fwd_hit2;
         default: return fwd_hit3;
      endcase
   endfunction

   function automatic logic [31:0] get_data(input int p);
      case (p)
         0: return fwd_data0;
         1: return fwd_data1;
         2: return fwd_data2;
         default: return fwd_data3;
      endcase
   endfunction

   // One clock cycle against the scoreboard; entered and left at posedge+1.
   task automatic cycle(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic dr, input string tag);
      int unsigned n;
      logic        rdy, ew, ew2, eh;
      ent_t        e1, e2;
      logic [31:0] ed;
      in_valid0 = v0; in_addr0 = a0; in_data0 = d0;
      in_valid1 = v1; in_addr1 = a1; in_data1 = d1;
      drain_en  = dr;
      fwd_addr0 = fa[0]; fwd_addr1 = fa[1]; fwd_addr2 = fa[2]; fwd_addr3 = fa[3];
      #1;
      n   = sb.size();
      rdy = (n <= DEPTH - 2);
      check({tag, " in_ready"}, 32'(in_ready), 32'(rdy));
      check({tag, " overflow"}, 32'(overflow), 32'(ovf_m));
      ew = 1'b0; ew2 = 1'b0; e1 = '{default: '0}; e2 = '{default: '0};
      if (dr && n >= 2) begin
         e2 = sb[1]; ew2 = 1'b1;
         if (sb[0].addr != sb[1].addr) begin e1 = sb[0]; ew = 1'b1; end
      end else if (dr && n == 1) begin
         e1 = sb[0]; ew = 1'b1;
      end
      check({tag, " we3"}, 32'(we3), 32'(ew));
      check({tag, " we3_2"}, 32'(we3_2), 32'(ew2));
      if (ew) begin
         check({tag, " wa3"}, 32'(wa3), 32'(e1.addr));
         check({tag, " wd3"}, wd3, e1.data);
      end
      if (ew2) begin
         check({tag, " wa3_2"}, 32'(wa3_2), 32'(e2.addr));
         check({tag, " wd3_2"}, wd3_2, e2.data);
      end
      for (int p = 0; p < 4; p++) begin
         eh = 1'b0; ed = '0;
         if (fa[p] != 0) begin
            foreach (sb[j]) if (sb[j].addr == fa[p]) begin eh = 1'b1; ed = sb[j].data; end
         end
         check($sformatf("%s fwd_hit%0d", tag, p), 32'(get_hit(p)), 32'(eh));
         check($sformatf("%s fwd_data%0d", tag, p), get_data(p), ed);
      end
      if (dr) repeat ((n >= 2) ? 2 : n) void'(sb.pop_front());
      if ((v0 || v1) && !rdy) ovf_m = 1'b1;
      else begin
         if (v0 && a0 != 0) sb.push_back('{a0, d0});
         if (v1 && a1 != 0) sb.push_back('{a1, d1});
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned pushed;
      int unsigned cyc;
      logic v0, v1, dr;
      logic [4:0] a0, a1;

      reset_n = 1'b0; ovf_m = 1'b0;
      in_valid0 = 0; in_addr0 = '0; in_data0 = '0;
      in_valid1 = 0; in_addr1 = '0; in_data1 = '0;
      drain_en = 0;
      fwd_addr0 = 5'd5; fwd_addr1 = '0; fwd_addr2 = '0; fwd_addr3 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset we3", 32'(we3), 0);
      check("reset we3_2", 32'(we3_2), 0);
      check("reset in_ready", 32'(in_ready), 1);
      check("reset overflow", 32'(overflow), 0);
      check("reset fwd_hit0", 32'(fwd_hit0), 0);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;

      //      v0 a0 d0    v1 a1 d1    dr fa  rdy we wa wd    we2 wa2 wd2  hit fd
      add_row(1, 5, 'h11, 0, 0, 0,    0, 5,  1,  0, 0, 0,    0,  0,  0,   0,  0);
      add_row(0, 0, 0,    0, 0, 0,    0, 5,  1,  0, 0, 0,    0,  0,  0,   1,  'h11);
      add_row(0, 0, 0,    0, 0, 0,    1, 5,  1,  1, 5, 'h11, 0,  0,  0,   1,  'h11);
      add_row(0, 0, 0,    0, 0, 0,    1, 5,  1,  0, 0, 0,    0,  0,  0,   0,  0);
      add_row(1, 3, 'hA,  1, 3, 'hB,  0, 3,  1,  0, 0, 0,    0,  0,  0,   0,  0);
      add_row(0, 0, 0,    0, 0, 0,    0, 3,  1,  0, 0, 0,    0,  0,  0,   1,  'hB);
      add_row(0, 0, 0,    0, 0, 0,    1, 3,  1,  0, 0, 0,    1,  3,  'hB, 1,  'hB);
      add_row(0, 0, 0,    0, 0, 0,    1, 3,  1,  0, 0, 0,    0,  0,  0,   0,  0);
      add_row(1, 0, 'hFF, 1, 7, 'h22, 0, 0,  1,  0, 0, 0,    0,  0,  0,   0,  0);
      add_row(0, 0, 0,    0, 0, 0,    0, 0,  1,  0, 0, 0,    0,  0,  0,   0,  0);
      add_row(0, 0, 0,    0, 0, 0,    1, 7,  1,  1, 7, 'h22, 0,  0,  0,   1,  'h22);
      add_row(0, 0, 0,    0, 0, 0,    1, 7,  1,  0, 0, 0,    0,  0,  0,   0,  0);
      add_row(0, 0, 0,    1, 9, 'h33, 1, 9,  1,  0, 0, 0,    0,  0,  0,   0,  0);
      add_row(0, 0, 0,    0, 0, 0,    1, 9,  1,  1, 9, 'h33, 0,  0,  0,   1,  'h33);
      add_row(0, 0, 0,    0, 0, 0,    0, 9,  1,  0, 0, 0,    0,  0,  0,   0,  0);

      foreach (tbl[i]) begin
         in_valid0 = tbl[i].v0; in_addr0 = tbl[i].a0; in_data0 = tbl[i].d0;
         in_valid1 = tbl[i].v1; in_addr1 = tbl[i].a1; in_data1 = tbl[i].d1;
         drain_en  = tbl[i].dr; fwd_addr0 = tbl[i].fa;
         fwd_addr1 = '0; fwd_addr2 = '0; fwd_addr3 = '0;
         #1;
         check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
         check($sformatf("vec%0d we3", i), 32'(we3), 32'(tbl[i].we));
         if (tbl[i].we) begin
            check($sformatf("vec%0d wa3", i), 32'(wa3), 32'(tbl[i].wa));
            check($sformatf("vec%0d wd3", i), wd3, tbl[i].wd);
         end
         check($sformatf("vec%0d we3_2", i), 32'(we3_2), 32'(tbl[i].we2));
         if (tbl[i].we2) begin
            check($sformatf("vec%0d wa3_2", i), 32'(wa3_2), 32'(tbl[i].wa2));
            check($sformatf("vec%0d wd3_2", i), wd3_2, tbl[i].wd2);
         end
         check($sformatf("vec%0d fwd_hit0", i), 32'(fwd_hit0), 32'(tbl[i].hit));
         check($sformatf("vec%0d fwd_data0", i), fwd_data0, tbl[i].fd);
         @(posedge clk); #1;
      end

      // Fill to DEPTH-1, then one rejected push that must never be written.
      fa[0] = 5'd20; fa[1] = 5'd3; fa[2] = 5'd7; fa[3] = 5'd0;
      for (int k = 1; k < DEPTH; k++)
         cycle(1'b1, 5'(k), 32'h100 + 32'(k), 1'b0, '0, '0, 1'b0, $sformatf("fill%0d", k));
      cycle(1'b1, 5'd20, 32'hDEAD, 1'b0, '0, '0, 1'b0, "ovf_push");
      repeat (2) cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, "ovf_hold");
      repeat (5) cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, "ovf_drain");

      // Random traffic through several pointer wraps, never pushing when full.
      pushed = 0;
      cyc = 0;
      while ((pushed < 3 * DEPTH || sb.size() != 0) && cyc < 2000) begin
         v0 = 1'($urandom_range(0, 1)); a0 = 5'($urandom_range(0, 7));
         v1 = 1'($urandom_range(0, 1)); a1 = 5'($urandom_range(0, 7));
         dr = ($urandom_range(0, 2) != 0);
         if (pushed >= 3 * DEPTH) begin v0 = 0; v1 = 0; dr = 1; end
         if (sb.size() > DEPTH - 2) begin v0 = 0; v1 = 0; end
         for (int p = 0; p < 4; p++) fa[p] = 5'($urandom_range(0, 7));
         pushed += int'(v0 && a0 != 0) + int'(v1 && a1 != 0);
         cycle(v0, a0, $urandom, v1, a1, $urandom, dr, $sformatf("rnd%0d", cyc));
         cyc++;
      end
      check("rnd queue empty within budget", 32'(sb.size()), 0);

      // Four entries pending, reset lands in the middle of a drain cycle.
      fa[0] = 5'd11; fa[1] = 5'd12; fa[2] = 5'd13; fa[3] = 5'd14;
      cycle(1'b1, 5'd11, 32'hA11, 1'b1, 5'd12, 32'hA12, 1'b0, "pre_rst0");
      cycle(1'b1, 5'd13, 32'hA13, 1'b1, 5'd14, 32'hA14, 1'b0, "pre_rst1");
      in_valid0 = 0; in_valid1 = 0; drain_en = 1;
      #1;
      check("mid_drain we3", 32'(we3), 1);
      check("mid_drain wa3", 32'(wa3), 11);
      check("mid_drain we3_2", 32'(we3_2), 1);
      #1 reset_n = 1'b0;
      #1;
      check("async_rst we3", 32'(we3), 0);
      check("async_rst we3_2", 32'(we3_2), 0);
      check("async_rst in_ready", 32'(in_ready), 1);
      check("async_rst overflow", 32'(overflow), 0);
      check("async_rst fwd_hit0", 32'(fwd_hit0), 0);
      sb.delete();
      ovf_m = 1'b0;
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      repeat (4) cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, "post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
